// File: rtl/gsvp_pkg.sv
// Shared definitions for the grayscale video pipe.
// Holds the mode encodings and the default luma weights.
package gsvp_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_GRAY   = 2'd1,
      MODE_THRESH = 2'd2,
      MODE_INV    = 2'd3
   } mode_e;

   // BT.601 luma weights scaled by 256; they sum to 256, so white maps to full scale.
   localparam int DEF_COEF_R = 76;
   localparam int DEF_COEF_G = 151;
   localparam int DEF_COEF_B = 29;

endpackage

// File: rtl/gsvp_luma_pipe.sv
// Three-stage luma datapath: weighted products, rounded sum, then shift/saturate/mode select.
// Mode and threshold travel with each pixel, so a config change never splits a pixel's processing.
module gsvp_luma_pipe
   import gsvp_pkg::*;
#(
   parameter int COMP_W = 8,
   parameter int COEF_W = 8
) (
   input  logic                clk_pix,
   input  logic                rst_n,
   input  logic [3*COMP_W-1:0] pix_i,
   input  logic [COEF_W-1:0]   coef_r_i,
   input  logic [COEF_W-1:0]   coef_g_i,
   input  logic [COEF_W-1:0]   coef_b_i,
   input  mode_e               mode_i,
   input  logic [COMP_W-1:0]   thresh_i,
   output logic [3*COMP_W-1:0] pix_o
);

   localparam int PIX_W  = 3 * COMP_W;
   localparam int PROD_W = COMP_W + COEF_W;
   localparam int SUM_W  = PROD_W + 2;
   localparam logic [SUM_W-1:0]  ROUND    = SUM_W'(1) << (COEF_W - 1);
   localparam logic [COMP_W-1:0] COMP_MAX = '1;

   logic [PROD_W-1:0] prod_r_d, prod_g_d, prod_b_d;
   logic [PROD_W-1:0] prod_r_q, prod_g_q, prod_b_q;
   logic [SUM_W-1:0]  sum_d, sum_q;
   logic [PIX_W-1:0]  pix1_q, pix2_q, pix3_d, pix3_q;
   mode_e             mode1_q, mode2_q;
   logic [COMP_W-1:0] thresh1_q, thresh2_q;
   logic [SUM_W-1:0]  shifted;
   logic [COMP_W-1:0] gray;

   always_comb begin
      prod_r_d = PROD_W'(pix_i[PIX_W-1 -: COMP_W])  * PROD_W'(coef_r_i);
      prod_g_d = PROD_W'(pix_i[2*COMP_W-1 -: COMP_W]) * PROD_W'(coef_g_i);
      prod_b_d = PROD_W'(pix_i[COMP_W-1:0])         * PROD_W'(coef_b_i);
      sum_d    = SUM_W'(prod_r_q) + SUM_W'(prod_g_q) + SUM_W'(prod_b_q) + ROUND;
   end

   // Two extra sum bits cover three full-scale products, so saturation only happens after the shift.
   always_comb begin
      shifted = sum_q >> COEF_W;
      gray    = (shifted > SUM_W'(COMP_MAX)) ? COMP_MAX : shifted[COMP_W-1:0];
      pix3_d  = pix2_q;
      case (mode2_q)
         MODE_BYPASS: pix3_d = pix2_q;
         MODE_GRAY:   pix3_d = {3{gray}};
         MODE_THRESH: pix3_d = (gray >= thresh2_q) ? '1 : '0;
         MODE_INV:    pix3_d = {3{COMP_MAX - gray}};
      endcase
   end

   // NOTE: non-blocking assignments so each stage captures the previous stage's pre-edge value.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         prod_r_q  <= '0;
         prod_g_q  <= '0;
         prod_b_q  <= '0;
         pix1_q    <= '0;
         mode1_q   <= MODE_BYPASS;
         thresh1_q <= '0;
         sum_q     <= '0;
         pix2_q    <= '0;
         mode2_q   <= MODE_BYPASS;
         thresh2_q <= '0;
         pix3_q    <= '0;
      end else begin
         prod_r_q  <= prod_r_d;
         prod_g_q  <= prod_g_d;
         prod_b_q  <= prod_b_d;
         pix1_q    <= pix_i;
         mode1_q   <= mode_i;
         thresh1_q <= thresh_i;
         sum_q     <= sum_d;
         pix2_q    <= pix1_q;
         mode2_q   <= mode1_q;
         thresh2_q <= thresh1_q;
         pix3_q    <= pix3_d;
      end
   end

   assign pix_o = pix3_q;

endmodule

// File: rtl/grayscale_video_pipe.sv
// RGB-to-gray video pipe with frame-synchronous configuration commit.
// Holds the shadow/active config registers and the 3-deep sync delay around gsvp_luma_pipe.
module grayscale_video_pipe
   import gsvp_pkg::*;
#(
   parameter int COMP_W     = 8,
   parameter int COEF_W     = 8,
   parameter int RST_COEF_R = DEF_COEF_R,
   parameter int RST_COEF_G = DEF_COEF_G,
   parameter int RST_COEF_B = DEF_COEF_B
) (
   input  logic                clk_pix,
   input  logic                rst_n,
   input  logic [3*COMP_W-1:0] vid_data,
   input  logic                pHSync,
   input  logic                pVSync,
   input  logic                pVDE,
   input  logic [1:0]          cfg_mode,
   input  logic [COEF_W-1:0]   cfg_coef_r,
   input  logic [COEF_W-1:0]   cfg_coef_g,
   input  logic [COEF_W-1:0]   cfg_coef_b,
   input  logic [COMP_W-1:0]   cfg_thresh,
   input  logic                cfg_valid,
   output logic                cfg_pending,
   output logic [3*COMP_W-1:0] OUT_vid_data,
   output logic                OUT_pHSync,
   output logic                OUT_pVSync,
   output logic                OUT_pVDE,
   output logic                OUT_clk_pix
);

   typedef struct packed {
      mode_e             mode;
      logic [COEF_W-1:0] coef_r;
      logic [COEF_W-1:0] coef_g;
      logic [COEF_W-1:0] coef_b;
      logic [COMP_W-1:0] thresh;
   } cfg_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } sync_t;

   localparam cfg_t RST_CFG = '{
      mode:   MODE_GRAY,
      coef_r: COEF_W'(RST_COEF_R),
      coef_g: COEF_W'(RST_COEF_G),
      coef_b: COEF_W'(RST_COEF_B),
      thresh: COMP_W'(1) << (COMP_W - 1)
   };

   cfg_t              cfg_in, shadow_d, shadow_q, active_d, active_q;
   logic              pending_d, pending_q;
   sync_t             sync_in;
   sync_t [2:0]       sync_q;
   logic              vs_rise;
   logic [3*COMP_W-1:0] pipe_pix;

   always_comb begin
      cfg_in  = '{mode: mode_e'(cfg_mode), coef_r: cfg_coef_r, coef_g: cfg_coef_g,
                  coef_b: cfg_coef_b, thresh: cfg_thresh};
      sync_in = '{hs: pHSync, vs: pVSync, de: pVDE};
   end

   // The first sync-delay tap doubles as the registered VSync copy for edge detection.
   assign vs_rise = pVSync & ~sync_q[0].vs;

   // NOTE: every next-state variable gets its default first, so no branch can infer a latch.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (vs_rise && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      // Applied after the commit so a coincident strobe re-arms pending with the new values.
      if (cfg_valid) begin
         shadow_d  = cfg_in;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q  <= RST_CFG;
         active_q  <= RST_CFG;
         pending_q <= 1'b0;
         sync_q    <= '0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         sync_q    <= {sync_q[1:0], sync_in};
      end
   end

   gsvp_luma_pipe #(
      .COMP_W (COMP_W),
      .COEF_W (COEF_W)
   ) u_luma_pipe (
      .clk_pix  (clk_pix),
      .rst_n    (rst_n),
      .pix_i    (vid_data),
      .coef_r_i (active_q.coef_r),
      .coef_g_i (active_q.coef_g),
      .coef_b_i (active_q.coef_b),
      .mode_i   (active_q.mode),
      .thresh_i (active_q.thresh),
      .pix_o    (pipe_pix)
   );

   assign OUT_pHSync   = sync_q[2].hs;
   assign OUT_pVSync   = sync_q[2].vs;
   assign OUT_pVDE     = sync_q[2].de;
   assign OUT_vid_data = sync_q[2].de ? pipe_pix : '0;
   assign cfg_pending  = pending_q;
   assign OUT_clk_pix  = clk_pix;

endmodule

// File: tb/tb_grayscale_video_pipe.sv
// Scoreboard bench for grayscale_video_pipe: the driver queues hand-computed pixels,
// the monitor pops them whenever OUT_pVDE is high and checks sync alignment every cycle.
module tb_grayscale_video_pipe;

   logic        clk_pix = 1'b0;
   logic        rst_n;
   logic [23:0] vid_data;
   logic        pHSync, pVSync, pVDE;
   logic [1:0]  cfg_mode;
   logic [7:0]  cfg_coef_r, cfg_coef_g, cfg_coef_b, cfg_thresh;
   logic        cfg_valid;
   logic        cfg_pending;
   logic [23:0] OUT_vid_data;
   logic        OUT_pHSync, OUT_pVSync, OUT_pVDE, OUT_clk_pix;

   int errors = 0;
   int checks = 0;
   logic [23:0] exp_q[$];

   logic       cfg_arm = 1'b0;
   logic [1:0] arm_mode;
   logic [7:0] arm_r, arm_g, arm_b, arm_t;

   logic [23:0] tab_in  [5] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000};
   logic [23:0] tab_exp [5] = '{24'h4C4C4C, 24'h969696, 24'h1D1D1D, 24'hFFFFFF, 24'h000000};

   grayscale_video_pipe dut (
      .clk_pix      (clk_pix),
      .rst_n        (rst_n),
      .vid_data     (vid_data),
      .pHSync       (pHSync),
      .pVSync       (pVSync),
      .pVDE         (pVDE),
      .cfg_mode     (cfg_mode),
      .cfg_coef_r   (cfg_coef_r),
      .cfg_coef_g   (cfg_coef_g),
      .cfg_coef_b   (cfg_coef_b),
      .cfg_thresh   (cfg_thresh),
      .cfg_valid    (cfg_valid),
      .cfg_pending  (cfg_pending),
      .OUT_vid_data (OUT_vid_data),
      .OUT_pHSync   (OUT_pHSync),
      .OUT_pVSync   (OUT_pVSync),
      .OUT_pVDE     (OUT_pVDE),
      .OUT_clk_pix  (OUT_clk_pix)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_cfg(input logic [1:0] m, input logic [7:0] r, g, b, t);
      arm_mode = m; arm_r = r; arm_g = g; arm_b = b; arm_t = t;
      cfg_arm  = 1'b1;
   endtask

   // One pixel-clock cycle of stimulus; an armed config rides along as a cfg_valid strobe.
   task automatic drive(input logic h, v, de, input logic [23:0] d, input logic [23:0] e);
      @(negedge clk_pix);
      pHSync = h; pVSync = v; pVDE = de; vid_data = d;
      if (cfg_arm) begin
         cfg_mode = arm_mode; cfg_coef_r = arm_r; cfg_coef_g = arm_g;
         cfg_coef_b = arm_b; cfg_thresh = arm_t;
         cfg_valid = 1'b1;
         cfg_arm   = 1'b0;
      end else begin
         cfg_valid = 1'b0;
      end
      if (de) exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
   endtask

   task automatic check_pending(input string name, input logic exp);
      @(posedge clk_pix);
      #1;
      check(name, 32'(cfg_pending), 32'(exp));
   endtask

   task automatic check_quiet(input string name);
      check({name, "_data"},    32'(OUT_vid_data), 32'h0);
      check({name, "_syncs"},   32'({OUT_pHSync, OUT_pVSync, OUT_pVDE}), 32'h0);
      check({name, "_pending"}, 32'(cfg_pending), 32'h0);
   endtask

   initial begin : monitor
      logic [2:0]  hist [3];
      logic [2:0]  samp;
      logic [23:0] e;
      for (int i = 0; i < 3; i++) hist[i] = 3'b000;
      forever begin
         @(posedge clk_pix);
         samp = {pHSync, pVSync, pVDE};
         if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist[i] = 3'b000;
         end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = samp;
         end
         #1;
         check("sync_delay", 32'({OUT_pHSync, OUT_pVSync, OUT_pVDE}), 32'(hist[2]));
         if (OUT_pVDE) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pixel: got 0x%0h with no pixel expected at %0t",
                        OUT_vid_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("pixel", 32'(OUT_vid_data), 32'(e));
            end
         end else begin
            check("blank_zero", 32'(OUT_vid_data), 32'h0);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int k;
      rst_n = 1'b0;
      vid_data = '0; pHSync = 1'b0; pVSync = 1'b0; pVDE = 1'b0;
      cfg_mode = 2'd0; cfg_coef_r = '0; cfg_coef_g = '0; cfg_coef_b = '0; cfg_thresh = '0;
      cfg_valid = 1'b0;

      repeat (2) @(negedge clk_pix);
      check_quiet("reset");
      check("clk_passthru_lo", 32'(OUT_clk_pix), 32'(clk_pix));
      @(negedge clk_pix);
      rst_n = 1'b1;
      @(posedge clk_pix);
      #1;
      check("clk_passthru_hi", 32'(OUT_clk_pix), 32'(clk_pix));

      // Reset defaults: gray mode, 76/151/29.
      idle(2);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'h4C4C4C);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
      drive(1'b0, 1'b0, 1'b1, 24'h00FF00, 24'h969696);
      drive(1'b0, 1'b0, 1'b1, 24'h0000FF, 24'h1D1D1D);
      drive(1'b0, 1'b0, 1'b1, 24'h808080, 24'h808080);
      idle(2);

      // Full-scale weights saturate.
      set_cfg(2'd1, 8'd255, 8'd255, 8'd255, 8'd128);
      idle(1);
      check_pending("pend_after_cfg", 1'b1);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      check_pending("pend_after_commit", 1'b0);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'hFEFEFE);
      idle(2);

      // Inverted gray.
      set_cfg(2'd3, 8'd76, 8'd151, 8'd29, 8'd128);
      idle(1);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'h000000, 24'hFFFFFF);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'hB3B3B3);
      idle(2);

      // Threshold 100, then threshold equal to gray.
      set_cfg(2'd2, 8'd76, 8'd151, 8'd29, 8'd100);
      idle(1);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'h000000);
      drive(1'b0, 1'b0, 1'b1, 24'h00FF00, 24'hFFFFFF);
      drive(1'b0, 1'b0, 1'b1, 24'h0000FF, 24'h000000);
      idle(1);
      set_cfg(2'd2, 8'd76, 8'd151, 8'd29, 8'd150);
      idle(1);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'h00FF00, 24'hFFFFFF);
      idle(2);

      // Back to gray, then request bypass mid-frame.
      set_cfg(2'd1, 8'd76, 8'd151, 8'd29, 8'd128);
      idle(1);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'h4C4C4C);
      set_cfg(2'd0, 8'd76, 8'd151, 8'd29, 8'd128);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'h4C4C4C);
      check_pending("pend_mid_frame", 1'b1);
      drive(1'b1, 1'b0, 1'b1, 24'hFF0000, 24'h4C4C4C);
      drive(1'b0, 1'b0, 1'b0, 24'h123456, 24'h0);
      check_pending("pend_before_edge", 1'b1);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      check_pending("pend_after_edge", 1'b0);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'h123456, 24'h123456);
      drive(1'b0, 1'b0, 1'b0, 24'hABCDEF, 24'h0);
      idle(2);

      // cfg_valid coincident with the VSync edge: A commits, B stays pending.
      set_cfg(2'd1, 8'd76, 8'd151, 8'd29, 8'd128);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'hFF0000);
      check_pending("pend_cfg_a", 1'b1);
      set_cfg(2'd3, 8'd76, 8'd151, 8'd29, 8'd128);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      check_pending("pend_coincident", 1'b1);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'h4C4C4C);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      check_pending("pend_cfg_b_commit", 1'b0);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'hB3B3B3);
      idle(2);

      // Several requests in one frame: the last one wins.
      set_cfg(2'd2, 8'd76, 8'd151, 8'd29, 8'd100);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'hB3B3B3);
      set_cfg(2'd0, 8'd76, 8'd151, 8'd29, 8'd128);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'hB3B3B3);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'h123456, 24'h123456);
      idle(2);

      // Reset mid-line with a pending config and pixels in flight.
      set_cfg(2'd3, 8'd10, 8'd10, 8'd10, 8'd10);
      drive(1'b1, 1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
      drive(1'b1, 1'b0, 1'b1, 24'hFF0000, 24'hFF0000);
      @(negedge clk_pix);
      rst_n = 1'b0;
      pHSync = 1'b0; pVSync = 1'b0; pVDE = 1'b0; vid_data = '0; cfg_valid = 1'b0;
      cfg_arm = 1'b0;
      exp_q.delete();
      #1;
      check_quiet("mid_reset");
      @(negedge clk_pix);
      rst_n = 1'b1;
      idle(2);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'h4C4C4C);
      drive(1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
      check_pending("pend_after_reset", 1'b0);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 24'hFF0000, 24'h4C4C4C);
      idle(2);

      // Random syncs under default gray; pixels drawn from a hand-computed table.
      for (int n = 0; n < 60; n++) begin
         k = int'($urandom_range(0, 4));
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               tab_in[k], tab_exp[k]);
      end

      idle(6);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/grayscale_video_pipe.md
GRAYSCALE_VIDEO_PIPE -- requirements
Module: grayscale_video_pipe

Interface
REQ-001 SHALL have parameter COMP_W, default 8, meaning bits per colour component; video bus is 3*COMP_W.
REQ-002 SHALL have parameter COEF_W, default 8, meaning unsigned coefficient width; the weighted sum is normalised by 2^COEF_W.
REQ-003 SHALL have parameter RST_COEF_R / RST_COEF_G / RST_COEF_B, defaults 76 / 151 / 29, meaning reset luma weights.
REQ-004 SHALL have port clk_pix, input, 1, the single pixel clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port vid_data, input, 3*COMP_W, RGB pixel with R in the MSBs and B in the LSBs.
REQ-007 SHALL have ports pHSync, pVSync and pVDE, input, 1 each, meaning input sync and data-enable.
REQ-008 SHALL have port cfg_mode, input, 2, meaning 0 bypass, 1 gray, 2 threshold, 3 inverted gray.
REQ-009 SHALL have ports cfg_coef_r, cfg_coef_g and cfg_coef_b, input, COEF_W each, meaning requested weights.
REQ-010 SHALL have port cfg_thresh, input, COMP_W, meaning requested binarisation threshold.
REQ-011 SHALL have port cfg_valid, input, 1, a single-cycle strobe that captures all cfg_* inputs.
REQ-012 SHALL have port cfg_pending, output, 1, high while captured config awaits frame-boundary commit.
REQ-013 SHALL have port OUT_vid_data, output, 3*COMP_W, processed pixel.
REQ-014 SHALL have ports OUT_pHSync, OUT_pVSync and OUT_pVDE, output, 1 each, meaning syncs aligned to OUT_vid_data.
REQ-015 SHALL have port OUT_clk_pix, output, 1, a combinational pass-through of clk_pix.

Function
REQ-016 SHALL use a fixed latency of 3 clk_pix cycles from vid_data/sync input to the corresponding outputs.
REQ-017 SHALL delay pHSync, pVSync and pVDE through a 3-deep shift register, unchanged in value.
REQ-018 SHALL use three pipeline stages: S1 registers the three products; S2 registers the sum plus rounding constant 2^(COEF_W-1); S3 registers the shifted, saturated result after mode select.
REQ-019 SHALL size each product COMP_W+COEF_W bits and the sum COMP_W+COEF_W+2 bits, with no truncation before the shift.
REQ-020 SHALL compute gray = sum >> COEF_W, saturated to 2^COMP_W-1 when it exceeds that value.
REQ-021 SHALL, in mode 0, output vid_data delayed by 3 cycles; in mode 1, output gray on all channels; in mode 2, output all-ones if gray >= thresh else zero on all channels; in mode 3, output (2^COMP_W-1)-gray on all channels.
REQ-022 SHALL force OUT_vid_data to zero on any cycle where OUT_pVDE is 0, in every mode including bypass.
REQ-023 SHALL latch cfg_* into shadow registers and set cfg_pending when cfg_valid is 1.
REQ-024 SHALL, on the first cycle pVSync is 1 after being 0 (edge detected against a registered copy), copy the shadow registers into the active registers and clear cfg_pending, but only if cfg_pending is set.
REQ-025 SHALL give cfg_valid priority when cfg_valid and a pVSync rising edge coincide: the new values go to the shadow registers, the old pending values commit, and cfg_pending stays 1.
REQ-026 SHALL let the last cfg_valid before the edge win when several arrive within one frame.
REQ-027 SHALL change the active config only at the S1 input boundary, so every pixel in the pipe uses one consistent config and no frame mixes two configs.

Reset
REQ-028 SHALL, while rst_n is 0, drive OUT_vid_data, OUT_pHSync, OUT_pVSync, OUT_pVDE and cfg_pending to 0 and clear all pipeline and sync delay registers.
REQ-029 SHALL reset active and shadow weights to RST_COEF_*, mode to 1, and thresh to 2^(COMP_W-1).
REQ-030 SHALL discard pending config and in-flight pixels on reset mid-frame; after rst_n releases, outputs are valid 3 cycles after the first input.

Structure
REQ-031 SHALL place the mode encodings (MODE_BYPASS, MODE_GRAY, MODE_THRESH, MODE_INV) and the default coefficients in the shared package gsvp_pkg.
REQ-032 SHALL implement the S1-S3 arithmetic in one sub-module, gsvp_luma_pipe; the config shadow/commit logic and sync delay stay in the top level.

Verification
REQ-033 SHALL verify: defaults, mode 1, pVDE=1, vid_data=0xFF0000 -> OUT_vid_data=0x4C4C4C exactly 3 cycles later; 0xFFFFFF -> 0xFFFFFF.
REQ-034 SHALL verify: commit weights 255/255/255, white input -> saturated 0xFFFFFF; mode 3 with 0x000000 input -> 0xFFFFFF.
REQ-035 SHALL verify: mode 2, thresh=100, pure red (gray 76) -> 0x000000; pure green (gray 150) -> 0xFFFFFF.
REQ-036 SHALL verify: cfg_valid mid-frame with mode 0 -> output stays gray until the next pVSync rising edge, then bypass; cfg_pending is 1 in between and 0 afterwards.
REQ-037 SHALL verify: cfg_valid coincident with the pVSync edge -> the prior pending config commits and cfg_pending stays 1; rst_n pulsed mid-line -> all outputs 0 immediately and defaults restored.
REQ-038 SHALL verify: random syncs -> OUT_pHSync/OUT_pVSync/OUT_pVDE equal the inputs delayed by 3; OUT_vid_data is 0 whenever OUT_pVDE is 0.
